// File: rtl/csrng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csrng_pkg
// Description : CSRNG command encodings plus the state-store dump FSM types.
// Revision    : 1.0 - initial release
// ============================================================================
package csrng_pkg;

  typedef enum logic [2:0] {
    INV  = 3'h0,
    INS  = 3'h1,
    RES  = 3'h2,
    GEN  = 3'h3,
    UPD  = 3'h4,
    UNI  = 3'h5,
    GENB = 3'h6,
    GENU = 3'h7
  } acmd_e;

  localparam int unsigned c_dump_word_w = 32;

  typedef enum logic [0:0] {
    DUMP_IDLE   = 1'b0,
    DUMP_STREAM = 1'b1
  } dump_st_e;

endpackage
`default_nettype wire

// File: rtl/csrng_state_dump.sv
`default_nettype none
// ============================================================================
// Module      : csrng_state_dump
// Description : Snapshots one DRBG state and streams it as 32-bit words, LSW first.
// Revision    : 1.0 - initial release
// ============================================================================
module csrng_state_dump
  import csrng_pkg::*;
#(
  parameter int unsigned StateW = 418
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              req_i,
  input  logic              id_ok_i,
  input  logic [StateW-1:0] state_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       data_o,
  output logic              last_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned c_nw     = (StateW + c_dump_word_w - 1) / c_dump_word_w;
  localparam int unsigned c_sh_w   = c_nw * c_dump_word_w;
  localparam int unsigned c_idx_w  = (c_nw > 1) ? $clog2(c_nw) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nw - 1);

  dump_st_e            r_state;
  logic [c_sh_w-1:0]   r_shadow;
  logic [c_idx_w-1:0]  r_idx;
  logic                r_err;
  logic [31:0]         w_words [c_nw];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= DUMP_IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
    end else if (!enable_i) begin
      r_state <= DUMP_IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        DUMP_IDLE: begin
          if (req_i) begin
            if (id_ok_i) begin
              r_shadow <= c_sh_w'(state_i);
              r_idx    <= '0;
              r_state  <= DUMP_STREAM;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        DUMP_STREAM: begin
          if (ready_i) begin
            if (r_idx == c_last_idx) begin
              r_idx   <= '0;
              r_state <= DUMP_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= DUMP_IDLE;
      endcase
    end
  end

  for (genvar gw = 0; gw < c_nw; gw++) begin : g_word
    assign w_words[gw] = r_shadow[gw*c_dump_word_w +: c_dump_word_w];
  end

  assign valid_o = (r_state == DUMP_STREAM);
  assign busy_o  = valid_o;
  assign last_o  = valid_o && (r_idx == c_last_idx);
  assign data_o  = w_words[r_idx];
  assign err_o   = r_err;

endmodule
`default_nettype wire

// File: rtl/csrng_state_store.sv
`default_nettype none
// ============================================================================
// Module      : csrng_state_store
// Description : Per-instance DRBG state storage with status; optional serial
//               dump port enabled by CSRNG_STATE_STORE_DUMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module csrng_state_store
  import csrng_pkg::*;
#(
  parameter int unsigned NApps   = 4,
  parameter int unsigned StateId = 4,
  parameter int unsigned KeyLen  = 256,
  parameter int unsigned BlkLen  = 128,
  parameter int unsigned CtrLen  = 32,
  parameter int unsigned Cmd     = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [StateId-1:0] rd_id_i,
  output logic [KeyLen-1:0]  rd_key_o,
  output logic [BlkLen-1:0]  rd_v_o,
  output logic [CtrLen-1:0]  rd_res_ctr_o,
  output logic               rd_inst_st_o,
  output logic               rd_fips_o,
  output logic               rd_reseed_due_o,
  input  logic [CtrLen-1:0]  reseed_limit_i,
  input  logic               wr_req_i,
  input  logic [StateId-1:0] wr_id_i,
  input  logic [Cmd-1:0]     wr_ccmd_i,
  input  logic               wr_fips_i,
  input  logic               wr_sts_i,
  input  logic [KeyLen-1:0]  wr_key_i,
  input  logic [BlkLen-1:0]  wr_v_i,
  input  logic [CtrLen-1:0]  wr_res_ctr_i,
  output logic               sts_ack_o,
  output logic               sts_sts_o,
  output logic               wr_err_o,
  output logic [StateId-1:0] sts_id_o,
  input  logic               dump_req_i,
  input  logic [StateId-1:0] dump_id_i,
  output logic               dump_valid_o,
  input  logic               dump_ready_i,
  output logic [31:0]        dump_data_o,
  output logic               dump_last_o,
  output logic               dump_err_o,
  output logic               dump_busy_o
);

  localparam int unsigned c_state_w = 2 + KeyLen + BlkLen + CtrLen;
  localparam int unsigned c_slot_w  = (NApps > 1) ? $clog2(NApps) : 1;
  localparam logic [StateId:0] c_napps = (StateId + 1)'(NApps);

  // Layout, MSB to LSB: fips, inst_st, key, v, res_ctr
  logic [c_state_w-1:0] r_slot [NApps];
  logic [c_state_w-1:0] w_wr_state, w_wr_cur, w_rd_state;
  logic [c_slot_w-1:0]  w_wr_idx;
  logic                 w_wr_req, w_wr_bad, w_wr_ok, w_rd_ok;
  logic                 w_cmd_uni, w_cmd_inst;
  logic                 r_ack, r_sts, r_err;
  logic [StateId-1:0]   r_id;

  assign w_wr_req   = enable_i && wr_req_i;
  assign w_wr_bad   = ({1'b0, wr_id_i} >= c_napps);
  assign w_wr_ok    = w_wr_req && !w_wr_bad;
  assign w_wr_idx   = wr_id_i[c_slot_w-1:0];
  assign w_wr_cur   = r_slot[w_wr_idx];
  assign w_cmd_uni  = (wr_ccmd_i == Cmd'(UNI));
  assign w_cmd_inst = (wr_ccmd_i == Cmd'(INS)) || (wr_ccmd_i == Cmd'(RES)) ||
                      (wr_ccmd_i == Cmd'(GENU)) || (wr_ccmd_i == Cmd'(UPD));

  always_comb begin
    w_wr_state = {wr_fips_i, w_wr_cur[c_state_w-2], wr_key_i, wr_v_i, wr_res_ctr_i};
    if (w_cmd_uni) begin
      w_wr_state = '0;
    end else if (w_cmd_inst) begin
      w_wr_state[c_state_w-2] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NApps; gi++) begin : g_slot
    always_ff @(posedge clk_i) begin
      if (!enable_i) begin
        r_slot[gi] <= '0;
      end else if (w_wr_ok && (w_wr_idx == c_slot_w'(gi))) begin
        r_slot[gi] <= w_wr_state;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ack <= 1'b0;
      r_sts <= 1'b0;
      r_err <= 1'b0;
      r_id  <= '0;
    end else begin
      r_ack <= w_wr_req;
      r_err <= w_wr_req && w_wr_bad;
      if (w_wr_req) begin
        r_sts <= w_wr_bad | wr_sts_i;
        r_id  <= wr_id_i;
      end
    end
  end

  assign sts_ack_o = r_ack;
  assign sts_sts_o = r_sts;
  assign wr_err_o  = r_err;
  assign sts_id_o  = r_id;

  assign w_rd_ok    = ({1'b0, rd_id_i} < c_napps);
  assign w_rd_state = w_rd_ok ? r_slot[rd_id_i[c_slot_w-1:0]] : '0;

  assign rd_res_ctr_o    = w_rd_state[CtrLen-1:0];
  assign rd_v_o          = w_rd_state[CtrLen +: BlkLen];
  assign rd_key_o        = w_rd_state[CtrLen+BlkLen +: KeyLen];
  assign rd_inst_st_o    = w_rd_state[c_state_w-2];
  assign rd_fips_o       = w_rd_state[c_state_w-1];
  assign rd_reseed_due_o = rd_inst_st_o && (rd_res_ctr_o >= reseed_limit_i);

`ifdef CSRNG_STATE_STORE_DUMP_EN
  logic w_dump_ok;
  assign w_dump_ok = ({1'b0, dump_id_i} < c_napps);

  csrng_state_dump #(
    .StateW (c_state_w)
  ) u_dump (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .req_i    (dump_req_i),
    .id_ok_i  (w_dump_ok),
    .state_i  (r_slot[dump_id_i[c_slot_w-1:0]]),
    .valid_o  (dump_valid_o),
    .ready_i  (dump_ready_i),
    .data_o   (dump_data_o),
    .last_o   (dump_last_o),
    .err_o    (dump_err_o),
    .busy_o   (dump_busy_o)
  );
`else
  logic w_unused_dump;
  assign w_unused_dump = ^{dump_req_i, dump_id_i, dump_ready_i};
  assign dump_valid_o  = 1'b0;
  assign dump_data_o   = '0;
  assign dump_last_o   = 1'b0;
  assign dump_err_o    = 1'b0;
  assign dump_busy_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csrng_state_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_csrng_state_store
// Description : Scoreboard bench for csrng_state_store (dump checks under
//               CSRNG_STATE_STORE_DUMP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csrng_state_store;
  import csrng_pkg::*;

  logic         clk = 1'b0;
  logic         rst_ni, enable_i;
  logic [3:0]   rd_id_i, wr_id_i, sts_id_o, dump_id_i;
  logic [255:0] rd_key_o, wr_key_i;
  logic [127:0] rd_v_o, wr_v_i;
  logic [31:0]  rd_res_ctr_o, wr_res_ctr_i, reseed_limit_i, dump_data_o;
  logic         rd_inst_st_o, rd_fips_o, rd_reseed_due_o;
  logic         wr_req_i, wr_fips_i, wr_sts_i;
  logic [2:0]   wr_ccmd_i;
  logic         sts_ack_o, sts_sts_o, wr_err_o;
  logic         dump_req_i, dump_valid_o, dump_ready_i, dump_last_o, dump_err_o, dump_busy_o;

  always #5 clk = ~clk;

  csrng_state_store dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i),
    .rd_id_i(rd_id_i), .rd_key_o(rd_key_o), .rd_v_o(rd_v_o), .rd_res_ctr_o(rd_res_ctr_o),
    .rd_inst_st_o(rd_inst_st_o), .rd_fips_o(rd_fips_o), .rd_reseed_due_o(rd_reseed_due_o),
    .reseed_limit_i(reseed_limit_i),
    .wr_req_i(wr_req_i), .wr_id_i(wr_id_i), .wr_ccmd_i(wr_ccmd_i), .wr_fips_i(wr_fips_i),
    .wr_sts_i(wr_sts_i), .wr_key_i(wr_key_i), .wr_v_i(wr_v_i), .wr_res_ctr_i(wr_res_ctr_i),
    .sts_ack_o(sts_ack_o), .sts_sts_o(sts_sts_o), .wr_err_o(wr_err_o), .sts_id_o(sts_id_o),
    .dump_req_i(dump_req_i), .dump_id_i(dump_id_i), .dump_valid_o(dump_valid_o),
    .dump_ready_i(dump_ready_i), .dump_data_o(dump_data_o), .dump_last_o(dump_last_o),
    .dump_err_o(dump_err_o), .dump_busy_o(dump_busy_o)
  );

  typedef struct packed { logic sts; logic [3:0] id; logic err; } sts_exp_t;
  typedef struct packed { logic [31:0] data; logic last; } word_exp_t;

  sts_exp_t  sts_q[$];
  word_exp_t word_q[$];
  int        tests = 0;
  int        fails = 0;

  logic [255:0] m_key [4];
  logic [127:0] m_v   [4];
  logic [31:0]  m_ctr [4];
  logic         m_inst[4];
  logic         m_fips[4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [447:0] pack_slot(input int i);
    return {30'b0, m_fips[i], m_inst[i], m_key[i], m_v[i], m_ctr[i]};
  endfunction

  task automatic push_words(input int i, input int n);
    logic [447:0] s;
    word_exp_t    w;
    s = pack_slot(i);
    for (int k = 0; k < n; k++) begin
      w.data = s[k*32 +: 32];
      w.last = (k == 13);
      word_q.push_back(w);
    end
  endtask

  // Caller is at posedge+1; returns at the following posedge+1.
  task automatic do_write(input int id, input logic [2:0] cmd, input logic fips, input logic sts,
                          input logic [255:0] key, input logic [127:0] v, input logic [31:0] ctr);
    sts_exp_t e;
    wr_req_i = 1'b1; wr_id_i = 4'(id); wr_ccmd_i = cmd; wr_fips_i = fips; wr_sts_i = sts;
    wr_key_i = key; wr_v_i = v; wr_res_ctr_i = ctr;
    e.sts = (id >= 4) ? 1'b1 : sts;
    e.id  = 4'(id);
    e.err = (id >= 4);
    sts_q.push_back(e);
    if (id < 4) begin
      if (cmd == UNI) begin
        m_key[id] = '0; m_v[id] = '0; m_ctr[id] = '0; m_inst[id] = 1'b0; m_fips[id] = 1'b0;
      end else begin
        m_key[id] = key; m_v[id] = v; m_ctr[id] = ctr; m_fips[id] = fips;
        if (cmd == INS || cmd == RES || cmd == GENU || cmd == UPD) m_inst[id] = 1'b1;
      end
    end
    @(posedge clk); #1;
    wr_req_i = 1'b0;
  endtask

  task automatic check_slot(input int id);
    rd_id_i = 4'(id); #1;
    chk($sformatf("slot%0d_key", id), rd_key_o, m_key[id]);
    chk($sformatf("slot%0d_v", id), rd_v_o, m_v[id]);
    chk($sformatf("slot%0d_ctr", id), rd_res_ctr_o, m_ctr[id]);
    chk($sformatf("slot%0d_inst", id), rd_inst_st_o, m_inst[id]);
    chk($sformatf("slot%0d_fips", id), rd_fips_o, m_fips[id]);
  endtask

  // Monitor: pops expectations whenever the DUT presents a status or dump word.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst_ni === 1'b1) begin
      if (sts_ack_o) begin
        if (sts_q.size() == 0) begin
          chk("sts_unexpected_ack", 1, 0);
        end else begin
          sts_exp_t e;
          e = sts_q.pop_front();
          chk("sts_sts", sts_sts_o, e.sts);
          chk("sts_id", sts_id_o, e.id);
          chk("wr_err", wr_err_o, e.err);
        end
      end else if (wr_err_o) begin
        chk("wr_err_without_ack", 1, 0);
      end
      if (dump_valid_o && dump_ready_i) begin
        if (word_q.size() == 0) begin
          chk("dump_unexpected_word", dump_data_o, 0);
        end else begin
          word_exp_t w;
          w = word_q.pop_front();
          chk("dump_data", dump_data_o, w.data);
          chk("dump_last", dump_last_o, w.last);
        end
      end
      if (prev_stall && dump_valid_o) chk("dump_stable", dump_data_o, prev_data);
      prev_stall = dump_valid_o && !dump_ready_i;
      prev_data  = dump_data_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0; m_v[i] = '0; m_ctr[i] = '0; m_inst[i] = 1'b0; m_fips[i] = 1'b0;
    end
    rst_ni = 1'b0; enable_i = 1'b0; rd_id_i = '0; reseed_limit_i = '0;
    wr_req_i = 1'b0; wr_id_i = '0; wr_ccmd_i = '0; wr_fips_i = 1'b0; wr_sts_i = 1'b0;
    wr_key_i = '0; wr_v_i = '0; wr_res_ctr_i = '0;
    dump_req_i = 1'b0; dump_id_i = '0; dump_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sts_ack", sts_ack_o, 0);
    chk("rst_sts_sts", sts_sts_o, 0);
    chk("rst_sts_id", sts_id_o, 0);
    chk("rst_wr_err", wr_err_o, 0);
    chk("rst_dump_outs", {dump_valid_o, dump_last_o, dump_err_o, dump_busy_o, dump_data_o}, 0);

    @(posedge clk); #1;
    rst_ni = 1'b1; enable_i = 1'b1;
    check_slot(0);

    do_write(0, INS, 1'b1, 1'b0, {8{32'h0000_1111}}, {4{32'h2222_0000}}, 32'd100);
    do_write(1, RES, 1'b0, 1'b1, {32{8'h3C}}, {16{8'h5A}}, 32'hDEAD_BEEF);
    do_write(3, UPD, 1'b1, 1'b1, {16{16'h1234}}, {8{16'hFEDC}}, 32'd7);
    do_write(2, INS, 1'b1, 1'b0, {32{8'hA5}}, {16{8'h96}}, 32'd5);
    rd_id_i = 4'd2; #1;
    chk("ins_key", rd_key_o, {32{8'hA5}});
    chk("ins_inst", rd_inst_st_o, 1);
    chk("ins_ctr", rd_res_ctr_o, 32'd5);
    for (int i = 0; i < 4; i++) check_slot(i);

    do_write(2, UNI, 1'b1, 1'b0, {32{8'hFF}}, {16{8'hFF}}, 32'hFFFF_FFFF);
    rd_id_i = 4'd2; #1;
    chk("uni_all_zero", {rd_fips_o, rd_inst_st_o, rd_key_o[127:0], rd_v_o, rd_res_ctr_o}, 0);
    chk("uni_key_hi", rd_key_o, 0);
    for (int i = 0; i < 4; i++) check_slot(i);

    do_write(7, INS, 1'b1, 1'b0, {32{8'h77}}, {16{8'h77}}, 32'd77);
    for (int i = 0; i < 4; i++) check_slot(i);

    do_write(0, GENU, 1'b0, 1'b0, {32{8'h0F}}, {16{8'hF0}}, 32'd10);
    rd_id_i = 4'd0; reseed_limit_i = 32'd10; #1;
    chk("reseed_eq", rd_reseed_due_o, 1);
    reseed_limit_i = 32'd11; #1;
    chk("reseed_below", rd_reseed_due_o, 0);
    rd_id_i = 4'd2; reseed_limit_i = 32'd0; #1;
    chk("reseed_uninst", rd_reseed_due_o, 0);
    rd_id_i = 4'd9; #1;
    chk("rd_oob_key", rd_key_o, 0);
    chk("rd_oob_rest", {rd_inst_st_o, rd_fips_o, rd_v_o, rd_res_ctr_o}, 0);
    @(posedge clk); #1;

`ifdef CSRNG_STATE_STORE_DUMP_EN
    begin
      int cyc;
      push_words(1, 14);
      dump_id_i = 4'd1; dump_req_i = 1'b1;
      do_write(1, UPD, 1'b1, 1'b0, {32{8'hC3}}, {16{8'h11}}, 32'd42);
      dump_req_i = 1'b0;
      chk("dump_busy_start", dump_busy_o, 1);
      cyc = 0;
      while (dump_busy_o && cyc < 100) begin
        dump_ready_i = (cyc % 2 == 1);
        dump_req_i   = (cyc == 3);
        dump_id_i    = 4'd0;
        if (cyc == 6) begin
          do_write(1, RES, 1'b0, 1'b0, {32{8'h99}}, {16{8'h88}}, 32'd3);
        end else begin
          @(posedge clk); #1;
        end
        cyc++;
      end
      dump_ready_i = 1'b0; dump_req_i = 1'b0;
      chk("dump_done", dump_busy_o, 0);
      chk("dump_words_left", word_q.size(), 0);
      check_slot(1);

      dump_id_i = 4'd5; dump_req_i = 1'b1;
      @(posedge clk); #1;
      dump_req_i = 1'b0;
      chk("dump_err_pulse", dump_err_o, 1);
      chk("dump_err_idle", dump_busy_o, 0);
      @(posedge clk); #1;
      chk("dump_err_clear", dump_err_o, 0);

      push_words(3, 5);
      dump_id_i = 4'd3; dump_req_i = 1'b1;
      @(posedge clk); #1;
      dump_req_i = 1'b0; dump_ready_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      dump_ready_i = 1'b0;
      enable_i = 1'b0;
      @(posedge clk); #1;
      chk("en_drop_busy", dump_busy_o, 0);
      chk("en_drop_valid", dump_valid_o, 0);
      chk("en_drop_words_left", word_q.size(), 0);
    end
`else
    dump_id_i = 4'd1; dump_req_i = 1'b1; dump_ready_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("nodump_outs", {dump_valid_o, dump_last_o, dump_err_o, dump_busy_o, dump_data_o}, 0);
    end
    dump_req_i = 1'b0; dump_ready_i = 1'b0;
    enable_i = 1'b0;
    @(posedge clk); #1;
`endif
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0; m_v[i] = '0; m_ctr[i] = '0; m_inst[i] = 1'b0; m_fips[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) check_slot(i);
    enable_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("sts_q_empty", sts_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
